// File: rtl/cavlc_pkg.sv
// Shared constants and types for the CAVLC bitstream front end and its control FSM.
package cavlc_pkg;
  localparam int WORD_W     = 32;
  localparam int WINDOW_W   = 32;
  localparam int NUMSHIFT_W = 5;
  localparam int BUF_W      = 2 * WORD_W;

  typedef logic [6:0] count_t;
endpackage

// File: rtl/cavlc_shift_align.sv
// Combinational shift-then-append datapath producing the next buffer image and bit count.
module cavlc_shift_align
  import cavlc_pkg::*;
(
  input  logic [BUF_W-1:0]      buf_cur,
  input  count_t                count,
  input  logic                  shift_en,
  input  logic [NUMSHIFT_W-1:0] num_shift,
  input  logic                  load_en,
  input  logic [WORD_W-1:0]     in_data,
  output logic [BUF_W-1:0]      buf_next,
  output count_t                count_next
);

  logic [BUF_W-1:0] buf1;
  count_t           count1;

  always_comb begin
    buf1   = buf_cur;
    count1 = count;
    if (shift_en) begin
      buf1   = buf_cur << num_shift;
      count1 = count - count_t'(num_shift);
    end
    buf_next   = buf1;
    count_next = count1;
    // count1 <= WORD_W whenever a load is allowed, so the word lands right behind the valid bits.
    if (load_en) begin
      buf_next   = buf1 | ({in_data, {WORD_W{1'b0}}} >> count1);
      count_next = count1 + count_t'(WORD_W);
    end
  end

endmodule

// File: rtl/cavlc_bitstream_shifter.sv
// Bitstream buffer with left-aligned lookahead window; consumes bits on request from the CAVLC control FSM.
module cavlc_bitstream_shifter
  import cavlc_pkg::*;
(
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  Flush,
  input  logic                  InValid,
  input  logic [WORD_W-1:0]     InData,
  output logic                  InReady,
  input  logic                  ShiftEn,
  input  logic [NUMSHIFT_W-1:0] NumShift,
  output logic                  BarrelShifterReady,
  output logic [WINDOW_W-1:0]   Window,
  output logic [6:0]            BitCount,
  output logic [31:0]           BitsConsumed,
  output logic                  ShiftErr
);

  // Handshake: a word transfers on a rising edge where InValid && InReady; InReady
  // depends only on registered state, and InData is ignored when not transferred.

  logic [BUF_W-1:0] buf_q, buf_d, buf_aligned;
  count_t           count_q, count_d, count_aligned;
  logic [31:0]      bits_consumed_q, bits_consumed_d;
  logic             shift_err_q, shift_err_d;
  logic             shift_ok, load_ok;

  assign BarrelShifterReady = (count_q >= count_t'(WINDOW_W));
  assign InReady            = (count_q <= count_t'(BUF_W - WORD_W));
  assign Window             = buf_q[BUF_W-1 -: WINDOW_W];
  assign BitCount           = count_q;
  assign BitsConsumed       = bits_consumed_q;
  assign ShiftErr           = shift_err_q;

  assign shift_ok = ShiftEn & BarrelShifterReady;
  assign load_ok  = InValid & InReady;

  cavlc_shift_align u_align (
    .buf_cur    (buf_q),
    .count      (count_q),
    .shift_en   (shift_ok),
    .num_shift  (NumShift),
    .load_en    (load_ok),
    .in_data    (InData),
    .buf_next   (buf_aligned),
    .count_next (count_aligned)
  );

  always_comb begin
    buf_d           = buf_aligned;
    count_d         = count_aligned;
    bits_consumed_d = shift_ok ? bits_consumed_q + 32'(NumShift) : bits_consumed_q;
    shift_err_d     = ShiftEn & ~BarrelShifterReady;
    if (Flush) begin
      buf_d           = '0;
      count_d         = '0;
      bits_consumed_d = '0;
      shift_err_d     = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      buf_q           <= '0;
      count_q         <= '0;
      bits_consumed_q <= '0;
      shift_err_q     <= 1'b0;
    end else begin
      buf_q           <= buf_d;
      count_q         <= count_d;
      bits_consumed_q <= bits_consumed_d;
      shift_err_q     <= shift_err_d;
    end
  end

endmodule

// File: tb/tb_cavlc_bitstream_shifter.sv
// Bench for cavlc_bitstream_shifter: directed scenarios plus random traffic against a bit-queue model.
module tb_cavlc_bitstream_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        shift_en = 1'b0;
  logic [4:0]  num_shift = '0;
  logic        bs_ready;
  logic [31:0] window;
  logic [6:0]  bit_count;
  logic [31:0] bits_consumed;
  logic        shift_err;

  int errors = 0;
  int checks = 0;

  // Reference model: the stream as a queue of bits, oldest first.
  logic [0:0]  exp_q[$];
  logic [31:0] exp_consumed = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  cavlc_bitstream_shifter dut (
    .Clk                (clk),
    .nReset             (rst_n),
    .Flush              (flush),
    .InValid            (in_valid),
    .InData             (in_data),
    .InReady            (in_ready),
    .ShiftEn            (shift_en),
    .NumShift           (num_shift),
    .BarrelShifterReady (bs_ready),
    .Window             (window),
    .BitCount           (bit_count),
    .BitsConsumed       (bits_consumed),
    .ShiftErr           (shift_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_window();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++)
      if (i < exp_q.size()) w[31-i] = exp_q[i];
    return w;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_consumed = '0;
    exp_err = 1'b0;
  endtask

  task automatic model_edge(input logic f, input logic iv, input logic [31:0] d,
                            input logic se, input logic [4:0] n);
    bit ready, can_load;
    ready    = exp_q.size() >= 32;
    can_load = exp_q.size() <= 32;
    if (f) begin
      model_clear();
    end else begin
      exp_err = se && !ready;
      if (se && ready) begin
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
        exp_consumed += 32'(n);
      end
      if (iv && can_load)
        for (int i = 31; i >= 0; i--) exp_q.push_back(d[i]);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},    64'(bit_count),     64'(exp_q.size()));
    check({tag, ".window"},   64'(window),        64'(model_window()));
    check({tag, ".ready"},    64'(bs_ready),      64'(exp_q.size() >= 32));
    check({tag, ".inready"},  64'(in_ready),      64'(exp_q.size() <= 32));
    check({tag, ".err"},      64'(shift_err),     64'(exp_err));
    check({tag, ".consumed"}, 64'(bits_consumed), 64'(exp_consumed));
  endtask

  // Drive at negedge, let one rising edge pass, compare at the following negedge.
  task automatic step(input string tag, input logic f, input logic iv, input logic [31:0] d,
                      input logic se, input logic [4:0] n);
    flush = f; in_valid = iv; in_data = d; shift_en = se; num_shift = n;
    @(posedge clk);
    model_edge(f, iv, d, se, n);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b0, 5'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    compare_all("reset");

    step("fill1", 0, 1, 32'hA5A50F0F, 0, 0);
    check("tp_fill1_window", 64'(window), 64'hA5A50F0F);
    step("fill2", 0, 1, 32'h12345678, 0, 0);
    check("tp_fill2_count", 64'(bit_count), 64'd64);
    step("sh4", 0, 1, 32'hFFFFFFFF, 1, 5'd4);
    check("tp_sh4_window", 64'(window), 64'h5A50F0F1);
    step("sh28", 0, 0, '0, 1, 5'd28);
    check("tp_sh28_window", 64'(window), 64'h12345678);
    step("shld", 0, 1, 32'hDEADBEEF, 1, 5'd8);
    check("tp_shld_window", 64'(window), 64'h345678DE);
    check("tp_shld_count", 64'(bit_count), 64'd56);
    step("shz", 0, 0, '0, 1, 5'd0);

    step("fl0", 1, 0, '0, 0, 0);
    step("err", 0, 0, '0, 1, 5'd3);
    check("tp_err_pulse", 64'(shift_err), 64'd1);
    idle("err_end");
    check("tp_err_drop", 64'(shift_err), 64'd0);

    step("f40a", 0, 1, $urandom, 0, 0);
    step("f40b", 0, 0, '0, 1, 5'd24);
    step("f40c", 0, 1, $urandom, 0, 0);
    step("flpri", 1, 1, $urandom, 1, 5'd5);
    check("tp_flush_count", 64'(bit_count), 64'd0);

    step("r48a", 0, 1, $urandom, 0, 0);
    step("r48b", 0, 0, '0, 1, 5'd16);
    step("r48c", 0, 1, $urandom, 0, 0);
    check("tp_r48_count", 64'(bit_count), 64'd48);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    compare_all("areset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      logic f, iv, se;
      f  = ($urandom_range(0, 49) == 0);
      iv = ($urandom_range(0, 2) != 0);
      se = ($urandom_range(0, 3) != 0);
      step("rnd", f, iv, $urandom, se, 5'($urandom_range(0, 31)));
    end

    step("wfl", 1, 0, '0, 0, 0);
    step("wld", 0, 1, 32'hCAFEF00D, 0, 0);
    force dut.bits_consumed_q = 32'hFFFFFFFC;
    #1 release dut.bits_consumed_q;
    exp_consumed = 32'hFFFFFFFC;
    step("wrap", 0, 0, '0, 1, 5'd8);
    check("tp_wrap", 64'(bits_consumed), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
